// File: rtl/pipeline_ctrl.sv
// Front-end hazard/sequencing controller: load-use bubbles, fence draining, mispredict recovery, memory back-pressure.
// Define PIPE_CTRL_PERF_EN to add stall/flush cycle counters (stall_cycles_out, flush_cycles_out).
module pipeline_ctrl #(
    parameter int OUTSTANDING_W = 3,
    parameter int REDIRECT_LAT  = 1
) (
    input  logic                     clk,
    input  logic                     reset_n_in,
    input  logic [8:0]               dec_rs1_in,
    input  logic                     dec_rs1_read_in,
    input  logic [8:0]               dec_rs2_in,
    input  logic                     dec_rs2_read_in,
    input  logic                     dec_mem_fence_in,
    input  logic [8:0]               ex_rd_in,
    input  logic                     ex_rd_write_in,
    input  logic                     ex_mem_read_in,
    input  logic                     branch_mispredict_in,
    input  logic                     mem_busy_in,
    input  logic                     mem_issue_in,
    input  logic                     mem_done_in,
    output logic                     fetch_stall_out,
    output logic                     fetch_flush_out,
    output logic                     decode_stall_out,
    output logic                     decode_flush_out,
    output logic                     execute_stall_out,
    output logic                     mem_issue_ready_out,
    output logic [OUTSTANDING_W-1:0] outstanding_out
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]              stall_cycles_out,
    output logic [31:0]              flush_cycles_out
`endif
);

    typedef enum logic [1:0] {
        RUN,
        FENCE_WAIT,
        RECOVER
    } state_t;

    localparam logic [OUTSTANDING_W-1:0] CNT_MAX = '1;
    localparam logic [OUTSTANDING_W-1:0] CNT_ONE = OUTSTANDING_W'(1);

    state_t                   state, state_next;
    logic [OUTSTANDING_W-1:0] cnt, cnt_next;
    logic [3:0]               rcnt, rcnt_next;
    logic                     fence_hazard;
    logic                     load_use;

    assign fence_hazard = dec_mem_fence_in && ((cnt != '0) || ex_mem_read_in);
    assign load_use     = ex_mem_read_in && ex_rd_write_in && (ex_rd_in != 9'd0) &&
                          ((dec_rs1_read_in && (dec_rs1_in == ex_rd_in)) ||
                           (dec_rs2_read_in && (dec_rs2_in == ex_rd_in)));

    always_ff @(posedge clk or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state <= RUN;
            cnt   <= '0;
            rcnt  <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            rcnt  <= rcnt_next;
        end
    end

    // Done at zero and issue at full are dropped so the counter never wraps.
    always_comb begin
        cnt_next = cnt;
        case ({mem_issue_in, mem_done_in})
            2'b10:   if (cnt != CNT_MAX) cnt_next = cnt + CNT_ONE;
            2'b01:   if (cnt != '0)      cnt_next = cnt - CNT_ONE;
            default: cnt_next = cnt;
        endcase
    end

    always_comb begin
        state_next        = state;
        rcnt_next         = rcnt;
        fetch_stall_out   = 1'b0;
        fetch_flush_out   = 1'b0;
        decode_stall_out  = 1'b0;
        decode_flush_out  = 1'b0;
        execute_stall_out = 1'b0;
        if (!reset_n_in) begin
            state_next = RUN;
            rcnt_next  = 4'd0;
        end else if (mem_busy_in) begin
            fetch_stall_out   = 1'b1;
            decode_stall_out  = 1'b1;
            execute_stall_out = 1'b1;
        end else if (branch_mispredict_in) begin
            fetch_flush_out  = 1'b1;
            decode_flush_out = 1'b1;
            if (REDIRECT_LAT == 0) begin
                state_next = RUN;
                rcnt_next  = 4'd0;
            end else begin
                state_next = RECOVER;
                rcnt_next  = 4'(REDIRECT_LAT);
            end
        end else if (state == RECOVER) begin
            decode_flush_out = 1'b1;
            if (rcnt <= 4'd1) begin
                state_next = RUN;
                rcnt_next  = 4'd0;
            end else begin
                rcnt_next = rcnt - 4'd1;
            end
        end else if (fence_hazard) begin
            fetch_stall_out  = 1'b1;
            decode_flush_out = 1'b1;
            state_next       = FENCE_WAIT;
        end else begin
            // A waiting fence releases here; load-use can still bubble the same cycle.
            state_next = RUN;
            if (load_use) begin
                fetch_stall_out  = 1'b1;
                decode_flush_out = 1'b1;
            end
        end
    end

    always_comb begin
        mem_issue_ready_out = (cnt != CNT_MAX) && reset_n_in;
        if (!reset_n_in) mem_issue_ready_out = 1'b1;
        outstanding_out = cnt;
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset_n_in) begin
        if (!reset_n_in) begin
            stall_cycles_out <= 32'd0;
            flush_cycles_out <= 32'd0;
        end else begin
            if (fetch_stall_out)  stall_cycles_out <= stall_cycles_out + 32'd1;
            if (decode_flush_out) flush_cycles_out <= flush_cycles_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, directed multi-cycle sequences, randomized run vs. reference model.
module tb_pipeline_ctrl;

    localparam int OW   = 2;
    localparam int RL   = 2;
    localparam int MAXC = (1 << OW) - 1;

    typedef struct packed {
        logic [8:0] rs1;
        logic       rs1_rd;
        logic [8:0] rs2;
        logic       rs2_rd;
        logic       fence;
        logic [8:0] ex_rd;
        logic       ex_wr;
        logic       ex_ld;
        logic       mispred;
        logic       busy;
        logic       issue;
        logic       done;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [7:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n_in;
    logic [8:0]    dec_rs1_in, dec_rs2_in, ex_rd_in;
    logic          dec_rs1_read_in, dec_rs2_read_in, dec_mem_fence_in;
    logic          ex_rd_write_in, ex_mem_read_in, branch_mispredict_in;
    logic          mem_busy_in, mem_issue_in, mem_done_in;
    logic          fetch_stall_out, fetch_flush_out, decode_stall_out;
    logic          decode_flush_out, execute_stall_out, mem_issue_ready_out;
    logic [OW-1:0] outstanding_out;

    int checks = 0;
    int passes = 0;
    int m_cnt  = 0;
    int m_rec  = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.OUTSTANDING_W(OW), .REDIRECT_LAT(RL)) dut (
        .clk                 (clk),
        .reset_n_in          (reset_n_in),
        .dec_rs1_in          (dec_rs1_in),
        .dec_rs1_read_in     (dec_rs1_read_in),
        .dec_rs2_in          (dec_rs2_in),
        .dec_rs2_read_in     (dec_rs2_read_in),
        .dec_mem_fence_in    (dec_mem_fence_in),
        .ex_rd_in            (ex_rd_in),
        .ex_rd_write_in      (ex_rd_write_in),
        .ex_mem_read_in      (ex_mem_read_in),
        .branch_mispredict_in(branch_mispredict_in),
        .mem_busy_in         (mem_busy_in),
        .mem_issue_in        (mem_issue_in),
        .mem_done_in         (mem_done_in),
        .fetch_stall_out     (fetch_stall_out),
        .fetch_flush_out     (fetch_flush_out),
        .decode_stall_out    (decode_stall_out),
        .decode_flush_out    (decode_flush_out),
        .execute_stall_out   (execute_stall_out),
        .mem_issue_ready_out (mem_issue_ready_out),
        .outstanding_out     (outstanding_out)
    );

    function automatic stim_t mk(input logic [8:0] rs1, input logic rs1_rd,
                                 input logic [8:0] rs2, input logic rs2_rd,
                                 input logic fence, input logic [8:0] ex_rd,
                                 input logic ex_wr, input logic ex_ld,
                                 input logic mispred, input logic busy,
                                 input logic issue, input logic done);
        stim_t s;
        s.rs1 = rs1; s.rs1_rd = rs1_rd; s.rs2 = rs2; s.rs2_rd = rs2_rd;
        s.fence = fence; s.ex_rd = ex_rd; s.ex_wr = ex_wr; s.ex_ld = ex_ld;
        s.mispred = mispred; s.busy = busy; s.issue = issue; s.done = done;
        return s;
    endfunction

    task automatic applyStimulus(input stim_t s);
        dec_rs1_in           = s.rs1;
        dec_rs1_read_in      = s.rs1_rd;
        dec_rs2_in           = s.rs2;
        dec_rs2_read_in      = s.rs2_rd;
        dec_mem_fence_in     = s.fence;
        ex_rd_in             = s.ex_rd;
        ex_rd_write_in       = s.ex_wr;
        ex_mem_read_in       = s.ex_ld;
        branch_mispredict_in = s.mispred;
        mem_busy_in          = s.busy;
        mem_issue_in         = s.issue;
        mem_done_in          = s.done;
    endtask

    // Output vector layout: {fetch_stall, fetch_flush, decode_stall, decode_flush, execute_stall, ready, count}
    task automatic checkOutput(input string name, input logic [7:0] exp);
        logic [7:0] act;
        act = {fetch_stall_out, fetch_flush_out, decode_stall_out, decode_flush_out,
               execute_stall_out, mem_issue_ready_out, outstanding_out};
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Reference: remaining recovery flush cycles and an in-flight op count; fence wait needs no state of its own.
    function automatic logic [7:0] model_expect(input stim_t s);
        logic       rdy, lu, fh;
        logic [4:0] ctl;
        rdy = (m_cnt != MAXC);
        lu  = s.ex_ld && s.ex_wr && (s.ex_rd != 0) &&
              ((s.rs1_rd && s.rs1 == s.ex_rd) || (s.rs2_rd && s.rs2 == s.ex_rd));
        fh  = s.fence && (m_cnt != 0 || s.ex_ld);
        if (s.busy)            ctl = 5'b10101;
        else if (s.mispred)    ctl = 5'b01010;
        else if (m_rec > 0)    ctl = 5'b00010;
        else if (fh || lu)     ctl = 5'b10010;
        else                   ctl = 5'b00000;
        return {ctl, rdy, 2'(m_cnt)};
    endfunction

    task automatic model_update(input stim_t s);
        if (!s.busy) begin
            if (s.mispred)       m_rec = RL;
            else if (m_rec > 0)  m_rec = m_rec - 1;
        end
        if (s.issue && !s.done && m_cnt < MAXC)     m_cnt = m_cnt + 1;
        else if (s.done && !s.issue && m_cnt > 0)   m_cnt = m_cnt - 1;
    endtask

    task automatic do_reset();
        applyStimulus(mk(0,0,0,0,0,0,0,0,0,0,0,0));
        reset_n_in = 1'b0;
        m_cnt = 0;
        m_rec = 0;
        repeat (2) @(negedge clk);
        reset_n_in = 1'b1;
    endtask

    task automatic seq_step(input string name, input stim_t s, input logic [7:0] exp);
        applyStimulus(s);
        #1 checkOutput(name, exp);
        @(negedge clk);
    endtask

    vec_t  vecs[12];
    stim_t idle, fence_s, lu_s;

    initial begin
        idle = mk(0,0,0,0,0,0,0,0,0,0,0,0);
        vecs[0]  = '{mk(9'd0,0,9'd5,1,0,9'd5,1,1,0,0,0,0),     8'b10010100};
        vecs[1]  = '{mk(9'd7,1,9'd0,0,0,9'd7,1,1,0,0,0,0),     8'b10010100};
        vecs[2]  = '{mk(9'd0,1,9'd0,1,0,9'd0,1,1,0,0,0,0),     8'b00000100};
        vecs[3]  = '{mk(9'd0,0,9'd5,0,0,9'd5,1,1,0,0,0,0),     8'b00000100};
        vecs[4]  = '{mk(9'd5,1,9'd0,0,0,9'd5,1,0,0,0,0,0),     8'b00000100};
        vecs[5]  = '{mk(9'd5,1,9'd0,0,0,9'd5,0,1,0,0,0,0),     8'b00000100};
        vecs[6]  = '{mk(9'd0,0,9'd0,0,1,9'd0,0,0,0,0,0,0),     8'b00000100};
        vecs[7]  = '{mk(9'd1,1,9'd2,1,1,9'd3,1,1,0,0,0,0),     8'b10010100};
        vecs[8]  = '{mk(9'd0,0,9'd0,0,0,9'd0,0,0,0,0,0,0),     8'b00000100};
        vecs[9]  = '{mk(9'd5,1,9'd0,0,0,9'd5,1,1,0,1,0,0),     8'b10101100};
        vecs[10] = '{mk(9'h1A5,1,9'd0,0,0,9'h1A5,1,1,0,0,0,0), 8'b10010100};
        vecs[11] = '{mk(9'h1A5,1,9'd0,0,0,9'h0A5,1,1,0,0,0,0), 8'b00000100};

        reset_n_in = 1'b1;
        @(negedge clk);
        do_reset();
        reset_n_in = 1'b0;
        #1 checkOutput("reset_state", 8'b00000100);
        @(negedge clk);
        reset_n_in = 1'b1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].s);
            #1 checkOutput($sformatf("vector_%0d", i), vecs[i].exp);
            @(negedge clk);
        end

        // Load-use bubble lasts one cycle once the load leaves execute
        lu_s = mk(9'd0,0,9'd5,1,0,9'd5,1,1,0,0,0,0);
        seq_step("lu_bubble", lu_s, 8'b10010100);
        seq_step("lu_clear", mk(9'd0,0,9'd5,1,0,9'd0,0,0,0,0,0,0), 8'b00000100);

        // Fill counter, saturate, then drain a fence
        seq_step("issue_1", mk(0,0,0,0,0,0,0,0,0,0,1,0), 8'b00000100);
        seq_step("issue_2", mk(0,0,0,0,0,0,0,0,0,0,1,0), 8'b00000101);
        seq_step("issue_3", mk(0,0,0,0,0,0,0,0,0,0,1,0), 8'b00000110);
        seq_step("cnt_full", mk(0,0,0,0,0,0,0,0,0,0,1,0), 8'b00000011);
        seq_step("cnt_sat", mk(0,0,0,0,0,0,0,0,0,0,1,1), 8'b00000011);
        seq_step("issue_done", idle, 8'b00000011);
        fence_s = mk(0,0,0,0,1,0,0,0,0,0,0,1);
        seq_step("fence_cnt3", fence_s, 8'b10010011);
        seq_step("fence_cnt2", fence_s, 8'b10010110);
        seq_step("fence_cnt1", fence_s, 8'b10010101);
        seq_step("fence_release", mk(0,0,0,0,1,0,0,0,0,0,0,0), 8'b00000100);
        seq_step("done_at_zero", mk(0,0,0,0,0,0,0,0,0,0,0,1), 8'b00000100);
        seq_step("done_at_zero_hold", idle, 8'b00000100);

        // Mispredict: one fetch flush, 1+RL decode flushes
        seq_step("mp_cycle", mk(0,0,0,0,0,0,0,0,1,0,0,0), 8'b01010100);
        seq_step("mp_rec_a", idle, 8'b00010100);
        seq_step("mp_rec_b", idle, 8'b00010100);
        seq_step("mp_done", idle, 8'b00000100);

        // Back-pressure freezes recovery
        seq_step("mpb_cycle", mk(0,0,0,0,0,0,0,0,1,0,0,0), 8'b01010100);
        seq_step("mpb_busy_a", mk(0,0,0,0,0,0,0,0,0,1,0,0), 8'b10101100);
        seq_step("mpb_busy_b", mk(0,0,0,0,0,0,0,0,0,1,0,0), 8'b10101100);
        seq_step("mpb_rec_a", idle, 8'b00010100);
        seq_step("mpb_rec_b", idle, 8'b00010100);
        seq_step("mpb_done", idle, 8'b00000100);

        // Mispredict beats a pending fence
        seq_step("mf_issue", mk(0,0,0,0,0,0,0,0,0,0,1,0), 8'b00000100);
        seq_step("mf_both", mk(0,0,0,0,1,0,0,0,1,0,0,0), 8'b01010101);
        seq_step("mf_recover", mk(0,0,0,0,1,0,0,0,0,0,0,1), 8'b00010101);

        // Async reset in the middle of a fence wait
        do_reset();
        @(negedge clk);
        seq_step("rf_issue_1", mk(0,0,0,0,0,0,0,0,0,0,1,0), 8'b00000100);
        seq_step("rf_issue_2", mk(0,0,0,0,0,0,0,0,0,0,1,0), 8'b00000101);
        seq_step("rf_fence", mk(0,0,0,0,1,9'd3,1,1,0,0,0,0), 8'b10010110);
        applyStimulus(mk(0,0,0,0,1,9'd3,1,1,0,0,0,0));
        #1 checkOutput("rf_fence_wait", 8'b10010110);
        #2 reset_n_in = 1'b0;
        #1 checkOutput("rf_async_reset", 8'b00000100);
        @(negedge clk);
        reset_n_in = 1'b1;
        seq_step("rf_after_release", mk(0,0,0,0,1,0,0,0,0,0,0,0), 8'b00000100);

        // Randomized run against the reference model
        do_reset();
        @(negedge clk);
        for (int n = 0; n < 600; n++) begin
            stim_t s;
            s = mk(9'($urandom_range(0,3)), 1'($urandom_range(0,1)),
                   9'($urandom_range(0,3)), 1'($urandom_range(0,1)),
                   ($urandom_range(0,5) == 0),
                   9'($urandom_range(0,3)), 1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
                   ($urandom_range(0,11) == 0), ($urandom_range(0,6) == 0),
                   ($urandom_range(0,2) == 0), ($urandom_range(0,2) == 0));
            applyStimulus(s);
            #1 checkOutput($sformatf("random_%0d", n), model_expect(s));
            @(posedge clk);
            model_update(s);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the in-order front end. It watches the unregistered source/fence decode of the instruction entering decode, the instruction in execute, and the memory stage. It then drives the stall and flush controls of fetch, decode and execute. It handles load-use bubbles, fence draining against an outstanding-memory-op counter, multi-cycle branch-mispredict recovery and memory back-pressure.

## Interface
Parameters:
- OUTSTANDING_W, 3, width of outstanding-memory-op counter (max 2^W-1 in flight)
- REDIRECT_LAT, 1, extra cycles decode is flushed after a mispredict (0..15)

Ports:
- clk  in  1  clock
- reset_n_in  in  1  asynchronous, active-low reset
- dec_rs1_in  in  9  rs1 of instruction at decode input
- dec_rs1_read_in  in  1  rs1 is read
- dec_rs2_in  in  9  rs2 of instruction at decode input
- dec_rs2_read_in  in  1  rs2 is read
- dec_mem_fence_in  in  1  instruction at decode input is a fence
- ex_rd_in  in  9  destination of instruction in execute
- ex_rd_write_in  in  1  execute instruction writes rd
- ex_mem_read_in  in  1  execute instruction is a load
- branch_mispredict_in  in  1  execute resolved a mispredicted branch
- mem_busy_in  in  1  memory stage cannot accept/advance
- mem_issue_in  in  1  memory op issued to bus this cycle
- mem_done_in  in  1  memory op completed this cycle
- fetch_stall_out  out  1  hold fetch/decode-input instruction
- fetch_flush_out  out  1  squash fetch output
- decode_stall_out  out  1  freeze decode output registers
- decode_flush_out  out  1  decode emits bubble
- execute_stall_out  out  1  freeze execute
- mem_issue_ready_out  out  1  counter not full
- outstanding_out  out  OUTSTANDING_W  current outstanding count

## Operation
- State: FSM {RUN, FENCE_WAIT, RECOVER}, outstanding counter cnt, recovery counter rcnt (4 bits).
- Reset (reset_n_in low, async): state RUN, cnt=0, rcnt=0; all stall/flush outputs 0, mem_issue_ready_out=1, outstanding_out=0.
- Priority of combinational response, highest first:
  1. mem_busy_in: fetch_stall, decode_stall, execute_stall = 1; flushes 0; FSM and rcnt hold. cnt still updates.
  2. branch_mispredict_in: fetch_flush=1, decode_flush=1, stalls 0. Next state RECOVER with rcnt=REDIRECT_LAT. If REDIRECT_LAT=0, next state is RUN. This overrides FENCE_WAIT.
  3. RECOVER: decode_flush=1. rcnt decrements; at rcnt==1 next state is RUN.
  4. Fence: dec_mem_fence_in && (cnt!=0 || ex_mem_read_in) in RUN or FENCE_WAIT gives fetch_stall=1, decode_flush=1, and state FENCE_WAIT. The fence releases in the first cycle with cnt==0 and !ex_mem_read_in, and the state returns to RUN.
  5. Load-use: ex_mem_read_in && ex_rd_write_in && ex_rd_in!=0 && ((dec_rs1_read_in && dec_rs1_in==ex_rd_in) || (dec_rs2_read_in && dec_rs2_in==ex_rd_in)) gives fetch_stall=1, decode_flush=1. This is one bubble; no state change.
  6. Otherwise all outputs 0.
- cnt: issue&&!done gives +1, done&&!issue gives -1, both gives unchanged. Done at 0 is ignored. Issue at max saturates. mem_issue_ready_out = (cnt != 2^W-1).
- Register 0 never causes a hazard.

## Timing
- All stall/flush outputs are combinational from current inputs and registered state: zero-cycle latency.
- State, cnt and rcnt update on posedge clk.
- A mispredict yields 1+REDIRECT_LAT cycles of decode_flush_out and exactly 1 cycle of fetch_flush_out.
- Load-use inserts exactly one bubble. The next cycle the load has left execute and the hazard clears.
- Reset asserted mid-FENCE_WAIT or mid-RECOVER: outputs go to reset values immediately. cnt=0 regardless of in-flight ops.
- Simultaneous mispredict and fence: mispredict wins. The fence instruction is squashed and the FSM goes to RECOVER.

## Configuration
- PIPE_CTRL_PERF_EN defined: adds outputs stall_cycles_out[31:0] and flush_cycles_out[31:0]. They count cycles with fetch_stall_out=1 and decode_flush_out=1 respectively, wrap at 2^32, and reset to 0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Load x5 in execute (ex_mem_read=1, ex_rd=5) and decode reads rs2=5 -> fetch_stall=1, decode_flush=1 for exactly 1 cycle. With ex_rd=0: no stall.
- Three issues then fence at decode -> FENCE_WAIT, stalled while cnt=3,2,1. The fence releases in the cycle cnt reads 0.
- Mispredict with REDIRECT_LAT=2 -> fetch_flush 1 cycle, decode_flush 3 consecutive cycles, then RUN.
- mem_busy_in=1 during RECOVER with rcnt=2 -> all stalls 1, rcnt holds at 2. Recovery resumes after busy drops.
- OUTSTANDING_W=2: 3 issues -> cnt=3, mem_issue_ready_out=0. Simultaneous issue+done keeps 3. Done at 0 keeps 0.
- reset_n_in low during FENCE_WAIT with cnt=2 -> outputs 0, cnt=0 asynchronously, and state RUN after release.
